// File: rtl/keystroke_event_scanner.sv
// keystroke_event_scanner: synchronises and debounces raw key lines, turns every
// debounced edge into a {key, direction} event and queues it in an FWFT FIFO.
module keystroke_event_scanner #(
  parameter int NUM_KEYS        = 12,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 8,
  localparam int KEY_W = $clog2(NUM_KEYS),
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1),
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk_raw,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keystroke,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_press,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                evt_overflow,
  input  logic                clr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EVT_W = KEY_W + 1;

  logic [NUM_KEYS-1:0] sync_a;
  logic [NUM_KEYS-1:0] sync_b;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] toggle;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] sel_onehot;
  logic [NUM_KEYS-1:0] grant;
  logic [KEY_W-1:0]    sel_idx;
  logic                sel_found;
  logic                sel_state;
  logic                fifo_full;
  logic                do_push;
  logic                do_pop;
  logic                set_ovf;
  logic [EVT_W-1:0]    mem [FIFO_DEPTH];
  logic [EVT_W-1:0]    head;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= keystroke;
      sync_b <= sync_a;
    end
  end

  // A key flips on the edge its mismatch run would reach DEBOUNCE_CYCLES.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      toggle[i] = (sync_b[i] != key_state[i]) &&
                  (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
      key_state <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ((sync_b[i] == key_state[i]) || toggle[i]) db_cnt[i] <= '0;
        else db_cnt[i] <= db_cnt[i] + CNT_W'(1);
      end
      key_state <= key_state ^ toggle;
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found  = 1'b1;
        sel_idx    = KEY_W'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_state = |(key_state & sel_onehot);
  assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign do_pop    = evt_valid && evt_ready;
  assign do_push   = sel_found && (!fifo_full || do_pop);
  assign grant     = do_push ? sel_onehot : '0;

  // A key granted this cycle has already left, so a fresh toggle starts a new event.
  assign set_ovf = |(pending & ~grant & toggle);

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant) ^ toggle;
      if (set_ovf) evt_overflow <= 1'b1;
      else if (clr_overflow) evt_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_raw) begin
    if (do_push) mem[wr_ptr] <= {sel_idx, sel_state};
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign evt_valid = (fifo_level != '0);
  assign head      = evt_valid ? mem[rd_ptr] : '0;
  assign evt_key   = head[EVT_W-1:1];
  assign evt_press = head[0];

endmodule

// File: tb/tb_keystroke_event_scanner.sv
// tb_keystroke_event_scanner: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the key event path.
module tb_keystroke_event_scanner;

  localparam int NK    = 12;
  localparam int D     = 16;
  localparam int DEPTH = 8;

  logic          clk_raw = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keystroke = '0;
  logic [NK-1:0] key_state;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [3:0]    evt_key;
  logic          evt_press;
  logic [3:0]    fifo_level;
  logic          evt_overflow;
  logic          clr_overflow = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [NK-1:0] m_ks, m_s1, m_s2, m_pend;
  int            m_run [NK];
  logic          m_ovf;
  logic [4:0]    m_q [$];
  logic [4:0]    m_del [$];
  logic [4:0]    d_del [$];

  keystroke_event_scanner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_raw(clk_raw), .rst_n(rst_n), .keystroke(keystroke), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_press(evt_press),
    .fifo_level(fifo_level), .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
  );

  initial forever #5 clk_raw = ~clk_raw;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model_reset();
    m_ks = '0; m_s1 = '0; m_s2 = '0; m_pend = '0; m_ovf = 1'b0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    m_q.delete();
  endfunction

  // One clock of the behavioural model, using the inputs held across that edge.
  function automatic void model_step(input logic [NK-1:0] kin, input logic rdy, input logic clr);
    logic [NK-1:0] tog;
    bit pop, can, setovf;
    int sel;
    tog = '0;
    setovf = 0;
    for (int i = 0; i < NK; i++) begin
      if (m_s2[i] != m_ks[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          tog[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    pop = (m_q.size() != 0) && rdy;
    can = (m_q.size() < DEPTH) || pop;
    sel = -1;
    for (int i = NK - 1; i >= 0; i--) if (m_pend[i]) sel = i;
    if (pop) begin
      m_del.push_back(m_q[0]);
      void'(m_q.pop_front());
    end
    if (sel >= 0 && can) begin
      m_q.push_back({4'(sel), m_ks[sel]});
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < NK; i++) begin
      if (tog[i]) begin
        if (m_pend[i]) setovf = 1;
        m_pend[i] = ~m_pend[i];
      end
    end
    if (setovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_ks = m_ks ^ tog;
    m_s2 = m_s1;
    m_s1 = kin;
  endfunction

  function automatic logic [22:0] model_view();
    logic [4:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 5'd0;
    return {m_ks, (m_q.size() != 0), h, 4'(m_q.size()), m_ovf};
  endfunction

  function automatic logic [22:0] dut_view();
    return {key_state, evt_valid, evt_key, evt_press, fifo_level, evt_overflow};
  endfunction

  task automatic tick(input logic [NK-1:0] kin, input logic rdy, input logic clr);
    keystroke = kin;
    evt_ready = rdy;
    clr_overflow = clr;
    if (evt_valid && rdy) d_del.push_back({evt_key, evt_press});
    model_step(kin, rdy, clr);
    @(negedge clk_raw);
  endtask

  task automatic do_reset(input logic [NK-1:0] kin);
    rst_n = 1'b0;
    keystroke = kin;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_raw);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keystroke = '1;
    evt_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_raw);
    checks++;
    if (dut_view() !== 23'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", dut_view(), 23'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_press_pair();
    do_reset(12'h011);
    m_del.delete(); d_del.delete();
    for (int c = 1; c <= 20; c++) begin
      tick(12'h011, 1'b0, 1'b0);
      checks++;
      if (dut_view() !== model_view()) begin
        failures++;
        $display("[TB] FAIL press_pair_model c=%0d: got %h expected %h", c, dut_view(), model_view());
      end
      if (c == 17) begin
        checks++;
        if (key_state !== 12'h000) begin
          failures++;
          $display("[TB] FAIL press_pair_early: key_state=%h expected 000", key_state);
        end
      end
      if (c == 18) begin
        checks++;
        if ({key_state, evt_valid} !== {12'h011, 1'b0}) begin
          failures++;
          $display("[TB] FAIL press_pair_debounced: key_state=%h valid=%b expected 011/0", key_state, evt_valid);
        end
      end
      if (c == 19) begin
        checks++;
        if ({evt_valid, evt_key, evt_press, fifo_level} !== {1'b1, 4'd0, 1'b1, 4'd1}) begin
          failures++;
          $display("[TB] FAIL press_pair_first: v=%b key=%0d press=%b lvl=%0d expected 1/0/1/1", evt_valid, evt_key, evt_press, fifo_level);
        end
      end
    end
    checks++;
    if ({evt_valid, evt_key, evt_press, fifo_level} !== {1'b1, 4'd0, 1'b1, 4'd2}) begin
      failures++;
      $display("[TB] FAIL press_pair_level: v=%b key=%0d press=%b lvl=%0d expected 1/0/1/2", evt_valid, evt_key, evt_press, fifo_level);
    end
  endtask

  task automatic test_release_pair();
    logic [4:0] exp_ev [4];
    exp_ev[0] = {4'd0, 1'b1}; exp_ev[1] = {4'd4, 1'b1};
    exp_ev[2] = {4'd0, 1'b0}; exp_ev[3] = {4'd4, 1'b0};
    m_del.delete(); d_del.delete();
    for (int c = 1; c <= 25; c++) begin
      tick(12'h000, 1'b1, 1'b0);
      checks++;
      if (dut_view() !== model_view()) begin
        failures++;
        $display("[TB] FAIL release_model c=%0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    checks++;
    if (d_del.size() != 4) begin
      failures++;
      $display("[TB] FAIL release_count: got %0d expected 4", d_del.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (d_del[k] !== exp_ev[k]) begin
          failures++;
          $display("[TB] FAIL release_event%0d: got %h expected %h", k, d_del[k], exp_ev[k]);
        end
      end
    end
    checks++;
    if ({key_state, fifo_level} !== {12'h000, 4'd0}) begin
      failures++;
      $display("[TB] FAIL release_idle: key_state=%h lvl=%0d expected 000/0", key_state, fifo_level);
    end
  endtask

  task automatic test_glitch();
    do_reset(12'h000);
    m_del.delete(); d_del.delete();
    for (int c = 0; c < 10; c++) tick(12'h002, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) tick(12'h000, 1'b0, 1'b0);
    checks++;
    if ({key_state, evt_valid, fifo_level} !== {12'h000, 1'b0, 4'd0}) begin
      failures++;
      $display("[TB] FAIL glitch10: ks=%h v=%b lvl=%0d expected 000/0/0", key_state, evt_valid, fifo_level);
    end
    for (int c = 0; c < D - 1; c++) tick(12'h002, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) tick(12'h000, 1'b0, 1'b0);
    checks++;
    if ({key_state, fifo_level} !== {12'h000, 4'd0}) begin
      failures++;
      $display("[TB] FAIL glitch15: ks=%h lvl=%0d expected 000/0", key_state, fifo_level);
    end
    for (int c = 0; c < D; c++) tick(12'h002, 1'b0, 1'b0);
    tick(12'h000, 1'b0, 1'b0);
    tick(12'h000, 1'b0, 1'b0);
    checks++;
    if (key_state !== 12'h002) begin
      failures++;
      $display("[TB] FAIL pulse16: ks=%h expected 002", key_state);
    end
    for (int c = 0; c < 30; c++) tick(12'h000, 1'b0, 1'b0);
    checks++;
    if ({key_state, fifo_level, evt_key, evt_press} !== {12'h000, 4'd2, 4'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL pulse16_events: ks=%h lvl=%0d key=%0d press=%b expected 000/2/1/1", key_state, fifo_level, evt_key, evt_press);
    end
  endtask

  task automatic test_saturate();
    do_reset(12'h000);
    m_del.delete(); d_del.delete();
    for (int c = 0; c < 40; c++) tick(12'h3FF, 1'b0, 1'b0);
    checks++;
    if ({fifo_level, evt_key, evt_press} !== {4'd8, 4'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL saturate_full: lvl=%0d key=%0d expected 8/0", fifo_level, evt_key);
    end
    for (int c = 0; c < 20; c++) tick(12'h3FF, 1'b1, 1'b0);
    checks++;
    if (d_del.size() != 10) begin
      failures++;
      $display("[TB] FAIL saturate_count: got %0d expected 10", d_del.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (d_del[k] !== {4'(k), 1'b1}) begin
          failures++;
          $display("[TB] FAIL saturate_order%0d: got %h expected %h", k, d_del[k], {4'(k), 1'b1});
        end
      end
    end
    checks++;
    if ({evt_overflow, fifo_level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("[TB] FAIL saturate_end: ovf=%b lvl=%0d expected 0/0", evt_overflow, fifo_level);
    end
  endtask

  task automatic test_overflow();
    bit saw10;
    do_reset(12'h000);
    m_del.delete(); d_del.delete();
    for (int c = 0; c < 30; c++) tick(12'h0FF, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) tick(12'h4FF, 1'b0, 1'b0);
    checks++;
    if ({key_state, evt_overflow, fifo_level} !== {12'h4FF, 1'b0, 4'd8}) begin
      failures++;
      $display("[TB] FAIL ovf_pending: ks=%h ovf=%b lvl=%0d expected 4FF/0/8", key_state, evt_overflow, fifo_level);
    end
    for (int c = 0; c < 20; c++) tick(12'h0FF, 1'b0, 1'b0);
    checks++;
    if ({evt_overflow, fifo_level} !== {1'b1, 4'd8}) begin
      failures++;
      $display("[TB] FAIL ovf_set: ovf=%b lvl=%0d expected 1/8", evt_overflow, fifo_level);
    end
    tick(12'h0FF, 1'b0, 1'b1);
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear: ovf=%b expected 0", evt_overflow);
    end
    for (int c = 0; c < 14; c++) tick(12'h0FF, 1'b1, 1'b0);
    saw10 = 0;
    foreach (d_del[k]) if (d_del[k][4:1] == 4'd10) saw10 = 1;
    checks++;
    if (d_del.size() != 8 || saw10) begin
      failures++;
      $display("[TB] FAIL ovf_drain: count=%0d key10_seen=%0d expected 8/0", d_del.size(), saw10);
    end
    checks++;
    if (dut_view() !== model_view()) begin
      failures++;
      $display("[TB] FAIL ovf_model: got %h expected %h", dut_view(), model_view());
    end
  endtask

  task automatic test_midreset();
    do_reset(12'h000);
    m_del.delete(); d_del.delete();
    for (int c = 0; c < 25; c++) tick(12'h0A4, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 4'd3) begin
      failures++;
      $display("[TB] FAIL midreset_fill: lvl=%0d expected 3", fifo_level);
    end
    keystroke = 12'h024;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({evt_valid, fifo_level, key_state} !== {1'b0, 4'd0, 12'h000}) begin
      failures++;
      $display("[TB] FAIL midreset_async: v=%b lvl=%0d ks=%h expected 0/0/000", evt_valid, fifo_level, key_state);
    end
    @(negedge clk_raw);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(12'h024, 1'b0, 1'b0);
      checks++;
      if (dut_view() !== model_view()) begin
        failures++;
        $display("[TB] FAIL midreset_model c=%0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    checks++;
    if ({key_state, fifo_level, evt_key, evt_press} !== {12'h024, 4'd2, 4'd2, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midreset_replay: ks=%h lvl=%0d key=%0d press=%b expected 024/2/2/1", key_state, fifo_level, evt_key, evt_press);
    end
  endtask

  task automatic test_random();
    logic [NK-1:0] kv;
    logic rdy, clr;
    int pct [4];
    pct[0] = 10; pct[1] = 50; pct[2] = 90; pct[3] = 0;
    do_reset(12'h000);
    m_del.delete(); d_del.delete();
    kv = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5, 0) == 0) kv[$urandom_range(NK - 1, 0)] ^= 1'b1;
      rdy = ($urandom_range(99, 0) < pct[(n / 500) % 4]);
      clr = ($urandom_range(39, 0) == 0);
      tick(kv, rdy, clr);
      checks++;
      if (dut_view() !== model_view()) begin
        failures++;
        $display("[TB] FAIL random_model n=%0d: got %h expected %h", n, dut_view(), model_view());
      end
    end
    for (int n = 0; n < 200; n++) tick(kv, 1'b1, 1'b0);
    checks++;
    if (d_del != m_del) begin
      failures++;
      $display("[TB] FAIL random_stream: delivered=%0d expected=%0d", d_del.size(), m_del.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_pair();
    test_release_pair();
    test_glitch();
    test_saturate();
    test_overflow();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keystroke_event_scanner.md
Name: keystroke_event_scanner

Overview:
Parametrised successor to the fixed 12-bit keystroke input path of the core. Each raw key line is synchronised and debounced. Every debounced press or release becomes an event carrying the key index and direction. Events are queued in a first-word-fall-through FIFO with a valid/ready interface, so the tone/playback logic consumes them at its own pace instead of sampling a raw vector.

Parameters:
NUM_KEYS, 12, number of raw key lines (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a change (>=2)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
Derived localparams: KEY_W = clog2(NUM_KEYS), LVL_W = clog2(FIFO_DEPTH+1), CNT_W = clog2(DEBOUNCE_CYCLES+1)

Ports:
clk_raw  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
keystroke  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
key_state  out  NUM_KEYS  debounced key levels
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts the head this cycle
evt_key  out  KEY_W  key index of head event
evt_press  out  1  1 = press, 0 = release (head event)
fifo_level  out  LVL_W  number of queued events
evt_overflow  out  1  sticky: an event was lost
clr_overflow  in  1  synchronous clear of evt_overflow

Behaviour:
- Reset, asynchronous on rst_n low:
  - Synchroniser flops, debounce counters, key_state, pending bits and FIFO pointers go to 0.
  - evt_valid=0, evt_key=0, evt_press=0, fifo_level=0, evt_overflow=0.
  - Reset is allowed mid-operation; queued and pending events are discarded.
- Synchroniser: 2 flops per key. sync[i] lags keystroke[i] by 2 cycles.
- Debounce, per key:
  - A counter increments each cycle that sync[i] != key_state[i], and clears to 0 on any cycle they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, key_state[i] toggles on that edge and the counter clears.
  - Latency from a clean raw edge to key_state is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- Pending: a toggle of key_state[i] XORs pending[i].
  - If pending[i] was already 1, the toggle cancels it (net-zero pair lost) and sets evt_overflow.
  - Setting evt_overflow takes priority over clr_overflow in the same cycle.
- Arbiter: each cycle, the lowest-index set pending bit is selected.
  - If the FIFO can accept, the arbiter pushes {index, key_state[index]} and clears that pending bit.
  - The FIFO can accept when it is not full, or when it is full and a pop occurs in the same cycle.
  - At most one push per cycle. Simultaneous toggles drain in ascending index order on consecutive cycles.
  - When the FIFO is full with no pop, pending bits hold. Nothing is dropped except through the cancellation above.
  - Push latency: the event is visible at the FIFO head no earlier than 1 cycle after the key_state toggle (cycle after push).
- FIFO:
  - First-word-fall-through: evt_valid = (level != 0). evt_key/evt_press always show the head; they are 0 when empty.
  - Pop occurs when evt_valid && evt_ready. evt_ready while empty is ignored.
  - Simultaneous push and pop leaves the level unchanged, including at full.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges from 0 to FIFO_DEPTH.
- No combinational path from evt_ready to evt_valid, evt_key or evt_press. These outputs depend only on registered state.

Test Plan:
1. Defaults; keystroke=12'h011 held from reset release -> key_state=12'h011 at cycle 18. Events (key 0, press) then (key 4, press) on consecutive cycles; fifo_level reaches 2 with evt_ready=0.
2. keystroke[1] high for 10 cycles then low -> key_state[1] stays 0, no event, fifo_level=0.
3. From scenario 1 with evt_ready=1, keystroke=0 -> after 18 cycles, releases (key 0, 0) then (key 4, 0) delivered; level returns to 0.
4. evt_ready=0; keys 0..9 pressed together -> level saturates at 8 with keys 8 and 9 pending. Set evt_ready=1 -> all 10 events pop in index order 0..9, evt_overflow=0.
5. evt_ready=0, FIFO full, key 10 press pending; key 10 released after debounce -> pending cleared, evt_overflow=1, no key 10 event ever delivered. Pulse clr_overflow -> evt_overflow=0.
6. FIFO level 3 and keys 2 and 5 held; drive rst_n low mid-cycle -> evt_valid, fifo_level and key_state go to 0 immediately. After release, press events for keys 2 and 5 reappear after 18 cycles.
